ysyx_22050019_div_radix2: RTL
=============================

# ysyx_22050019_div_radix2

Iterative radix-2 restoring divider serving the ALU's divide/remainder requests over the valid/stall/ok handshake. Accepts one RV64M divide-class operation (64-bit or W-form, signed or unsigned), holds the pipeline via `div_stall` while iterating, then presents the result with `result_ok` until the consumer is ready. `div_out` is zero whenever no result is presented, because the ALU ORs it with the multiplier output.

## Interface
- No parameters; widths fixed at XLEN = 64.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `div_valid` in 1: a divide-class op occupies EX; held high while stalled.
- `div_type_i` in 8: one-hot op. Bit 0 rem, 1 remu, 2 remuw, 3 remw, 4 div, 5 divu, 6 divuw, 7 divw.
- `dividend_i` in 64: rs1 value.
- `divisor_i` in 64: rs2 value.
- `result_ready` in 1: consumer (not LSU-stalled) takes the result this cycle.
- `div_out` out 64: result, valid only while `result_ok`=1, else 0.
- `div_stall` out 1: hold the pipeline.
- `result_ok` out 1: `div_out` valid.

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE; all registers 0; outputs `div_out`=0, `div_stall`=0, `result_ok`=0.
- IDLE, `div_valid`=1: latch type and operands → CALC (→ DONE on a shortcut case, see Configuration).
- At accept: W-forms use bits [31:0] only, sign- or zero-extended per signedness. Signed ops store |a| and |b| plus sign flags: quotient negated if sa^sb, remainder negated if sa.
- CALC: one quotient bit per cycle. Shift {rem,quo} left by 1, trial-subtract |b|, keep if non-negative, set quotient LSB. Counter loads 63 (64-bit) or 31 (W); at 0 → DONE with the sign-fixed result registered.
- Divide by zero: quotient = all ones, remainder = dividend. Signed overflow (most-negative / −1, 64-bit or 32-bit): quotient = dividend, remainder = 0. These override the sign fixup.
- W-form results: low 32 bits sign-extended to 64 (all four, including divuw/remuw).
- DONE: `result_ok`=1, `div_out`=result. If `result_ready`=1 → IDLE; else hold DONE with output stable.
- `div_stall` = (IDLE & `div_valid`) | CALC. It is 0 in DONE.
- `div_valid` dropping in CALC (flush) → IDLE next cycle, no `result_ok`. `div_valid` is ignored in DONE.
- `rst` in any state → IDLE next edge. An in-flight result is discarded.
- Multi-bit `div_type_i`: undefined, not checked.

## Timing
- Accept cycle N: `div_stall`=1 combinationally.
- 64-bit op: CALC spans N+1..N+64, `result_ok` first high in N+65. W-form: first high in N+33. Shortcut: first high in N+1.
- Back-to-back: handshake in cycle M → IDLE at M+1. A new `div_valid` is accepted at M+1 at the earliest.
- No combinational path from `dividend_i`/`divisor_i` to outputs.

## Configuration
- `YSYX_22050019_DIV_SHORTCUT_EN` defined: divide by zero and signed overflow are detected at accept, go IDLE→DONE directly, 1-cycle latency.
- Macro undefined: these cases run the full CALC count. The same special-case result override is applied at CALC exit, so values are identical and only latency differs.

## Structure
- Package `ysyx_22050019_div_pkg` contains:
  - state enum;
  - `div_type_i` bit-index constants;
  - iteration counts 64/32;
  - XLEN.
- Sub-module `ysyx_22050019_div_opfix` (combinational): W-form extension, absolute value, sign flags, special-case detection.
- The FSM, shift register and counter stay in the top module.

## Test plan
- divu: 100 / 7 → `result_ok` exactly 65 cycles after accept, `div_out`=14. Then remu with the same operands → 2.
- divw: 0xFFFF_FFFF_FFFF_FFF9 (−7) / 2 → 0xFFFF_FFFF_FFFF_FFFD (−3), latency 33. remw with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- div: 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF. rem: 5 / 0 → 5. Latency 1 with macro, 65 without.
- div: 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, rem → 0. divw: 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.
- Hold `result_ready`=0 for 10 cycles in DONE → `div_out` stable, `div_stall`=0. Release → IDLE next cycle, `div_out`=0.
- Drop `div_valid` at CALC cycle 20, and separately assert `rst` mid-CALC → IDLE next edge, `result_ok` never asserts, all outputs 0.

Source files
------------

// File: rtl/ysyx_22050019_div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Holds the FSM state enum, one-hot op bit positions and iteration counts.
package ysyx_22050019_div_pkg;

    localparam int XLEN    = 64;
    localparam int ITER_64 = 64;
    localparam int ITER_32 = 32;
    localparam int CNT_W   = $clog2(ITER_64);

    // Bit positions inside the one-hot div_type_i vector
    localparam int OP_REM   = 0;
    localparam int OP_REMU  = 1;
    localparam int OP_REMUW = 2;
    localparam int OP_REMW  = 3;
    localparam int OP_DIV   = 4;
    localparam int OP_DIVU  = 5;
    localparam int OP_DIVUW = 6;
    localparam int OP_DIVW  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050019_div_radix2_if.sv
// ALU <-> divider handshake bundle (valid/stall/ok plus operands and result).
interface ysyx_22050019_div_radix2_if;
    import ysyx_22050019_div_pkg::*;

    logic            div_valid;
    logic [7:0]      div_type_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            result_ready;
    logic [XLEN-1:0] div_out;
    logic            div_stall;
    logic            result_ok;

    modport master (
        output div_valid,
        output div_type_i,
        output dividend_i,
        output divisor_i,
        output result_ready,
        input  div_out,
        input  div_stall,
        input  result_ok
    );

    modport slave (
        input  div_valid,
        input  div_type_i,
        input  dividend_i,
        input  divisor_i,
        input  result_ready,
        output div_out,
        output div_stall,
        output result_ok
    );

endinterface

// File: rtl/ysyx_22050019_div_opfix.sv
// Operand preparation: W-form extension, magnitudes, sign flags and the
// precomputed result for divide-by-zero / signed-overflow cases.
module ysyx_22050019_div_opfix
    import ysyx_22050019_div_pkg::*;
(
    input  logic [7:0]      div_type_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            is_w_o,
    output logic            is_rem_o,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    output logic            neg_quo_o,
    output logic            neg_rem_o,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o
);

    logic            is_signed_s;
    logic            sa_s;
    logic            sb_s;
    logic            div_zero_s;
    logic            overflow_s;
    logic [XLEN-1:0] a_ext_s;
    logic [XLEN-1:0] b_ext_s;
    logic [XLEN-1:0] min_s;
    logic [XLEN-1:0] quo_sp_s;
    logic [XLEN-1:0] rem_sp_s;
    logic [XLEN-1:0] res_sp_s;

    // Decode the op, extend operands and derive magnitudes and special cases
    always_comb begin
        is_w_o      = div_type_i[OP_REMUW] | div_type_i[OP_REMW] |
                      div_type_i[OP_DIVUW] | div_type_i[OP_DIVW];
        is_signed_s = div_type_i[OP_REM]   | div_type_i[OP_REMW] |
                      div_type_i[OP_DIV]   | div_type_i[OP_DIVW];
        is_rem_o    = div_type_i[OP_REM]   | div_type_i[OP_REMU] |
                      div_type_i[OP_REMUW] | div_type_i[OP_REMW];

        if (is_w_o) begin
            a_ext_s = is_signed_s ? sext_w(dividend_i[31:0]) : {32'd0, dividend_i[31:0]};
            b_ext_s = is_signed_s ? sext_w(divisor_i[31:0])  : {32'd0, divisor_i[31:0]};
            min_s   = {{33{1'b1}}, 31'd0};
        end else begin
            a_ext_s = dividend_i;
            b_ext_s = divisor_i;
            min_s   = {1'b1, 63'd0};
        end

        sa_s      = is_signed_s & a_ext_s[XLEN-1];
        sb_s      = is_signed_s & b_ext_s[XLEN-1];
        abs_a_o   = sa_s ? (~a_ext_s + 64'd1) : a_ext_s;
        abs_b_o   = sb_s ? (~b_ext_s + 64'd1) : b_ext_s;
        neg_quo_o = sa_s ^ sb_s;
        neg_rem_o = sa_s;

        div_zero_s = (b_ext_s == {XLEN{1'b0}});
        overflow_s = is_signed_s & (a_ext_s == min_s) & (b_ext_s == {XLEN{1'b1}});
        special_o  = div_zero_s | overflow_s;

        // Division by zero wins over overflow: divisor -1 is never zero anyway
        quo_sp_s = div_zero_s ? {XLEN{1'b1}} : a_ext_s;
        rem_sp_s = div_zero_s ? a_ext_s : {XLEN{1'b0}};
        res_sp_s = is_rem_o ? rem_sp_s : quo_sp_s;
        special_res_o = is_w_o ? sext_w(res_sp_s[31:0]) : res_sp_s;
    end

endmodule

// File: rtl/ysyx_22050019_div_radix2.sv
// Iterative radix-2 restoring divider for RV64M div/rem (incl. W-forms).
// Define YSYX_22050019_DIV_SHORTCUT_EN for 1-cycle divide-by-zero/overflow.
module ysyx_22050019_div_radix2
    import ysyx_22050019_div_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22050019_div_radix2_if.slave  bus
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            is_w_q, is_w_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] special_res_q, special_res_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            fix_is_w_s;
    logic            fix_is_rem_s;
    logic [XLEN-1:0] fix_abs_a_s;
    logic [XLEN-1:0] fix_abs_b_s;
    logic            fix_neg_quo_s;
    logic            fix_neg_rem_s;
    logic            fix_special_s;
    logic [XLEN-1:0] fix_special_res_s;

    logic [XLEN:0]   rem_sh_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_nx_s;
    logic [XLEN-1:0] quo_nx_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic [XLEN-1:0] res_raw_s;
    logic [XLEN-1:0] res_fin_s;
    logic            div_stall_s;

    ysyx_22050019_div_opfix u_opfix (
        .div_type_i    (bus.div_type_i),
        .dividend_i    (bus.dividend_i),
        .divisor_i     (bus.divisor_i),
        .is_w_o        (fix_is_w_s),
        .is_rem_o      (fix_is_rem_s),
        .abs_a_o       (fix_abs_a_s),
        .abs_b_o       (fix_abs_b_s),
        .neg_quo_o     (fix_neg_quo_s),
        .neg_rem_o     (fix_neg_rem_s),
        .special_o     (fix_special_s),
        .special_res_o (fix_special_res_s)
    );

    // One restoring step plus the sign fixup applied to the step's output
    always_comb begin
        rem_sh_s = {rem_q, quo_q[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, dvsr_q};
        if (trial_s[XLEN]) begin
            rem_nx_s = rem_sh_s[XLEN-1:0];
            quo_nx_s = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nx_s = trial_s[XLEN-1:0];
            quo_nx_s = {quo_q[XLEN-2:0], 1'b1};
        end

        quo_fix_s = neg_quo_q ? (~quo_nx_s + 64'd1) : quo_nx_s;
        rem_fix_s = neg_rem_q ? (~rem_nx_s + 64'd1) : rem_nx_s;
        res_raw_s = is_rem_q ? rem_fix_s : quo_fix_s;
        if (special_q) begin
            res_fin_s = special_res_q;
        end else if (is_w_q) begin
            res_fin_s = sext_w(res_raw_s[31:0]);
        end else begin
            res_fin_s = res_raw_s;
        end
    end

    // FSM next state, operand capture and iteration control
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        is_w_d        = is_w_q;
        is_rem_d      = is_rem_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        result_d      = result_q;
        div_stall_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.div_valid) begin
                    div_stall_s   = 1'b1;
                    is_w_d        = fix_is_w_s;
                    is_rem_d      = fix_is_rem_s;
                    neg_quo_d     = fix_neg_quo_s;
                    neg_rem_d     = fix_neg_rem_s;
                    special_d     = fix_special_s;
                    special_res_d = fix_special_res_s;
                    dvsr_d        = fix_abs_b_s;
                    rem_d         = {XLEN{1'b0}};
                    // W-forms start with the 32-bit dividend in the top half
                    quo_d         = fix_is_w_s ? {fix_abs_a_s[31:0], 32'd0} : fix_abs_a_s;
                    cnt_d         = fix_is_w_s ? CNT_W'(ITER_32 - 1) : CNT_W'(ITER_64 - 1);
`ifdef YSYX_22050019_DIV_SHORTCUT_EN
                    if (fix_special_s) begin
                        state_d  = DONE;
                        result_d = fix_special_res_s;
                    end else begin
                        state_d  = CALC;
                    end
`else
                    state_d       = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                div_stall_s = 1'b1;
                if (!bus.div_valid) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d  = DONE;
                        result_d = res_fin_s;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d  = IDLE;
                    result_d = {XLEN{1'b0}};
                end else begin
                    state_d  = DONE;
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = {XLEN{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            rem_q         <= {XLEN{1'b0}};
            quo_q         <= {XLEN{1'b0}};
            dvsr_q        <= {XLEN{1'b0}};
            is_w_q        <= 1'b0;
            is_rem_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= {XLEN{1'b0}};
            result_q      <= {XLEN{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            is_w_q        <= is_w_d;
            is_rem_q      <= is_rem_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            result_q      <= result_d;
        end
    end

    // result_q is cleared whenever DONE is left, so the ALU can OR it freely
    assign bus.div_out   = result_q;
    assign bus.result_ok = (state_q == DONE);
    assign bus.div_stall = div_stall_s;

endmodule
